// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: LSB-first bits are assembled in sreg, and each completed word is copied to Q.
// Q is valid one cycle after the Nth bit. There is no back-pressure on si; a word that completes while Q is still unconsumed is dropped and flagged on ovr.
module sipo_rx #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 si,
  input  logic                 si_valid,
  input  logic                 flush,
  output logic [N-1:0]         Q,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 busy,
  output logic [$clog2(N)-1:0] bit_cnt,
  output logic                 ovr
);

  localparam int CW = $clog2(N);

  logic [N-1:0] sreg;
  logic [N-1:0] next_word;
  logic         shift_en;
  logic         last_bit;
  logic         word_done;
  logic         sreg_lsb_unused;

  // sreg[0] is never read again: it is shifted out when the next bit arrives.
  assign sreg_lsb_unused = sreg[0];

  assign next_word = {si, sreg[N-1:1]};
  assign shift_en  = si_valid & ~flush;
  assign last_bit  = (bit_cnt == CW'(N - 1));
  assign word_done = shift_en & last_bit;
  assign busy      = (bit_cnt != '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg    <= '0;
      bit_cnt <= '0;
      Q       <= '0;
      q_valid <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (flush) begin
        sreg    <= '0;
        bit_cnt <= '0;
      end else if (si_valid) begin
        sreg    <= next_word;
        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      end

      // A completing word may replace Q in the same cycle that Q is consumed.
      if (word_done && (!q_valid || q_ready)) begin
        Q       <= next_word;
        q_valid <= 1'b1;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      if (flush)
        ovr <= 1'b0;
      else if (word_done && q_valid && !q_ready)
        ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx (N=4): scenario tasks with a queue of expected words.
module tb_sipo_rx;
  localparam int N = 4;

  logic         clk;
  logic         clr;
  logic         si;
  logic         si_valid;
  logic         flush;
  logic [N-1:0] Q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic [1:0]   bit_cnt;
  logic         ovr;

  int checks;
  int failures;
  logic [N-1:0] exp_q[$];

  sipo_rx #(.N(N)) dut (
    .clk(clk), .clr(clr), .si(si), .si_valid(si_valid), .flush(flush),
    .Q(Q), .q_valid(q_valid), .q_ready(q_ready), .busy(busy),
    .bit_cnt(bit_cnt), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    si = b;
    si_valid = 1'b1;
    step();
    si_valid = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    step();
    checks++;
    if ({Q, q_valid, ovr, busy, bit_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state: Q=%h q_valid=%b ovr=%b busy=%b bit_cnt=%0d, all must be 0",
               Q, q_valid, ovr, busy, bit_cnt);
    end
    clr = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    logic [1:0] exp_cnt;
    logic [N-1:0] w;
    bits = 4'b1101;  // sent as 1,0,1,1 (LSB first)
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'hD);
      send_bit(bits[i]);
      exp_cnt = 2'((i + 1) % 4);
      checks++;
      if (bit_cnt !== exp_cnt || busy !== (i != 3)) begin
        failures++;
        $display("FAIL basic_cnt bit%0d: bit_cnt=%0d busy=%b, want %0d/%b",
                 i, bit_cnt, busy, exp_cnt, (i != 3));
      end
    end
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w) begin
      failures++;
      $display("FAIL basic_word: q_valid=%b Q=%h, want 1/%h", q_valid, Q, w);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] bits;
    bits = 4'b1000;  // sent as 0,0,0,1; must be dropped
    q_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    checks++;
    if (Q !== 4'hD || q_valid !== 1'b1 || ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: Q=%h q_valid=%b ovr=%b, want d/1/1", Q, q_valid, ovr);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (ovr !== 1'b0 || Q !== 4'hD || q_valid !== 1'b1 || bit_cnt !== 2'd0) begin
      failures++;
      $display("FAIL overrun_flush: ovr=%b Q=%h q_valid=%b bit_cnt=%0d, want 0/d/1/0",
               ovr, Q, q_valid, bit_cnt);
    end
    q_ready = 1'b1;
    step();
    checks++;
    if (q_valid !== 1'b0 || Q !== 4'hD) begin
      failures++;
      $display("FAIL consume: q_valid=%b Q=%h, want 0/d", q_valid, Q);
    end
    step();
    step();
    q_ready = 1'b0;
    checks++;
    if (q_valid !== 1'b0 || ovr !== 1'b0 || Q !== 4'hD) begin
      failures++;
      $display("FAIL idle_ready: q_valid=%b ovr=%b Q=%h, want 0/0/d", q_valid, ovr, Q);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bits;
    logic [N-1:0] w;
    bits = 4'b0011;
    exp_q.push_back(4'h3);
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w) begin
      failures++;
      $display("FAIL b2b_first: q_valid=%b Q=%h, want 1/%h", q_valid, Q, w);
    end
    bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        q_ready = 1'b1;
        exp_q.push_back(4'hA);
      end
      send_bit(bits[i]);
    end
    q_ready = 1'b0;
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w || ovr !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: q_valid=%b Q=%h ovr=%b, want 1/%h/0", q_valid, Q, ovr, w);
    end
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [3:0] bits;
    logic [N-1:0] w;
    send_bit(1'b1);
    send_bit(1'b1);
    si = 1'b1;
    si_valid = 1'b1;
    flush = 1'b1;
    step();
    si_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (bit_cnt !== 2'd0 || busy !== 1'b0 || q_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: bit_cnt=%0d busy=%b q_valid=%b, want 0/0/0", bit_cnt, busy, q_valid);
    end
    bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'hA);
      send_bit(bits[i]);
    end
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w) begin
      failures++;
      $display("FAIL flush_word: q_valid=%b Q=%h, want 1/%h", q_valid, Q, w);
    end
  endtask

  task automatic test_async_clr();
    logic [N-1:0] w;
    // A word is still pending from the previous test and must be discarded.
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if ({Q, q_valid, ovr, busy, bit_cnt} !== '0) begin
      failures++;
      $display("FAIL async_clr: Q=%h q_valid=%b ovr=%b busy=%b bit_cnt=%0d, all must be 0",
               Q, q_valid, ovr, busy, bit_cnt);
    end
    step();
    clr = 1'b0;
    step();
    send_bit(1'b1);
    checks++;
    if (bit_cnt !== 2'd1) begin
      failures++;
      $display("FAIL clr_restart: bit_cnt=%0d, want 1", bit_cnt);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.push_back(4'hF);
    send_bit(1'b1);
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w) begin
      failures++;
      $display("FAIL clr_word: q_valid=%b Q=%h, want 1/%h", q_valid, Q, w);
    end
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    logic [N-1:0] w;
    bits = 4'b0110;  // sent as 0,1,1,0
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'h6);
      send_bit(bits[i]);
      if (i < 3) begin
        step();
        checks++;
        if (bit_cnt !== 2'(i + 1) || Q !== 4'hF || q_valid !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold bit%0d: bit_cnt=%0d Q=%h q_valid=%b, want %0d/f/0",
                   i, bit_cnt, Q, q_valid, i + 1);
        end
      end
    end
    w = exp_q.pop_front();
    checks++;
    if (q_valid !== 1'b1 || Q !== w) begin
      failures++;
      $display("FAIL gap_word: q_valid=%b Q=%h, want 1/%h", q_valid, Q, w);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    si       = 1'b0;
    si_valid = 1'b0;
    flush    = 1'b0;
    q_ready  = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_flush();
    test_async_clr();
    test_gapped();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected words left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter N, default 4, meaning received word width in bits; legal range N >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port si, input, 1, serial data bit, LSB of each word first.
REQ-005 SHALL have port si_valid, input, 1, si is sampled on this clock edge.
REQ-006 SHALL have port flush, input, 1, synchronous abort of a partially received word.
REQ-007 SHALL have port Q, output, N, assembled parallel word, registered.
REQ-008 SHALL have port q_valid, output, 1, Q holds an unconsumed word.
REQ-009 SHALL have port q_ready, input, 1, consumer accepts Q when q_valid is high.
REQ-010 SHALL have port busy, output, 1, a partial word is in progress (bit count != 0).
REQ-011 SHALL have port bit_cnt, output, clog2(N), bits received in the current word.
REQ-012 SHALL have port ovr, output, 1, sticky overrun flag.

Function
REQ-013 SHALL keep an internal N-bit shift register (sreg) separate from the output register Q, so Q stays stable while the next word is received.
REQ-014 On si_valid=1 and flush=0, sreg SHALL become {si, sreg[N-1:1]} (shift right, new bit enters at MSB).
REQ-015 On si_valid=1 and flush=0, bit_cnt SHALL increment; at bit_cnt = N-1 it SHALL wrap to 0 and that edge is the word-complete event.
REQ-016 On si_valid=0, sreg and bit_cnt SHALL hold.
REQ-017 At word-complete, the completed word SHALL be {si, sreg[N-1:1]}, i.e. the first received bit lands in Q[0].
REQ-018 At word-complete, if q_valid=0 or q_ready=1, Q SHALL load the completed word and q_valid SHALL be 1 on the next cycle (latency: Q valid one cycle after the Nth bit's edge).
REQ-019 At word-complete, if q_valid=1 and q_ready=0, the completed word SHALL be dropped, Q and q_valid SHALL hold, and ovr SHALL be set to 1.
REQ-020 With q_valid=1 and q_ready=1 and no word-complete that cycle, q_valid SHALL clear to 0 next cycle; Q SHALL hold its last value.
REQ-021 A simultaneous q_ready handshake and word-complete SHALL produce back-to-back words, with q_valid staying 1 and Q updating, and no overrun.
REQ-022 q_ready with q_valid=0 SHALL have no effect.
REQ-023 flush=1 SHALL clear bit_cnt and sreg to 0 on the next edge, take priority over a concurrent si_valid (bit discarded), and leave Q and q_valid unchanged.
REQ-024 ovr SHALL remain 1 until clr or flush; flush SHALL clear ovr even if the same cycle would set it.
REQ-025 busy SHALL equal (bit_cnt != 0), combinationally from registered bit_cnt.
REQ-026 The block SHALL use no handshake back-pressure on si; the source is free-running and overrun is reported only via ovr.

Reset
REQ-027 While clr=1, Q, sreg and bit_cnt SHALL be 0, and q_valid, ovr and busy SHALL be 0, regardless of clock.
REQ-028 clr asserted mid-word SHALL discard the partial word; the first si_valid after release SHALL be counted as bit 0.
REQ-029 clr asserted while q_valid=1 SHALL discard the pending word.

Verification (N=4)
REQ-030 Reset, then send bits 1,0,1,1 with si_valid on four consecutive edges -> Q=4'hD, q_valid=1 one cycle after the 4th edge; busy=1 after bit 1 and 0 after bit 4; bit_cnt sequence is 1,2,3,0.
REQ-031 Hold q_ready=0 after word 0xD, then send 0,0,0,1 -> Q stays 0xD, ovr=1; pulse flush -> ovr=0, Q still 0xD, q_valid still 1.
REQ-032 With q_valid=1 (Q=0x3), assert q_ready on the same edge as the 4th bit of word 0xA -> q_valid stays 1, Q=0xA, ovr=0.
REQ-033 Send bits 1,1 then flush together with si_valid, si=1, then send 0,1,0,1 -> Q=4'hA, no stale bits.
REQ-034 Send 2 bits, assert clr asynchronously between edges -> all outputs 0 immediately; then send 1,1,1,1 -> Q=4'hF.
REQ-035 Send gapped si_valid (one idle cycle between bits) carrying 0,1,1,0 -> Q=4'h6; sreg and bit_cnt hold during gaps.
